// File: rtl/pc_fetch_if.sv
// ============================================================================
// Module      : pc_fetch_if
// Description : Instruction-bus bundle between the fetch stage and its memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata,
        output err
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// Module      : pc_fetch
// Description : IF stage - owns the PC, runs one instruction-bus read at a
//               time, handles delay-slot branches, flush and fetch faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          EXC_ADEL = 0,
    parameter int          EXC_IBE  = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        stall,
    input  wire logic        flush,
    input  wire logic [31:0] flush_pc,
    input  wire logic        branch_en,
    input  wire logic [31:0] branch_pc,
    pc_fetch_if.master       ibus,
    output logic      [31:0] if_pc,
    output logic      [31:0] if_inst,
    output logic      [31:0] if_excp,
    output logic             if_stall
);

    localparam logic [31:0] c_adel_mask = 32'd1 << EXC_ADEL;
    localparam logic [31:0] c_ibe_mask  = 32'd1 << EXC_IBE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_if_inst;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_excp;
    logic        r_pend_br;
    logic [31:0] r_br_target;
    logic [31:0] r_req_addr;

    logic        w_aligned;
    logic        w_advance;
    logic        w_load_buf;
    logic [31:0] w_cap_inst;
    logic [31:0] w_cap_excp;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_next_pc;

    assign w_aligned = (r_pc[1:0] == 2'b00);
    assign w_advance = (r_state == ST_DONE) && !stall && !flush;

    // Delay-slot redirect: a branch resolved on the advance edge itself
    // applies to that advance; otherwise a pending branch is consumed.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (branch_en) begin
            w_next_pc = branch_pc;
        end else if (r_pend_br) begin
            w_next_pc = r_br_target;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_buf  = 1'b0;
        w_cap_inst  = 32'd0;
        w_cap_excp  = 32'd0;
        w_req       = 1'b0;
        w_addr      = r_pc;
        case (r_state)
            ST_IDLE: begin
                if (w_aligned) begin
                    // Withhold the request on a flush so it is never withdrawn un-acked.
                    w_req = !flush;
                    if (flush) begin
                        w_state_nxt = ST_IDLE;
                    end else if (ibus.ack) begin
                        w_load_buf  = 1'b1;
                        w_cap_inst  = ibus.rdata;
                        w_cap_excp  = ibus.err ? c_ibe_mask : 32'd0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end else if (!flush) begin
                    w_load_buf  = 1'b1;
                    w_cap_excp  = c_adel_mask;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_BUSY: begin
                w_req = 1'b1;
                if (ibus.ack) begin
                    if (flush) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load_buf  = 1'b1;
                        w_cap_inst  = ibus.rdata;
                        w_cap_excp  = ibus.err ? c_ibe_mask : 32'd0;
                        w_state_nxt = ST_DONE;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                w_req  = 1'b1;
                w_addr = r_req_addr;
                if (ibus.ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (flush || !stall) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_inst <= 32'd0;
            r_buf_excp <= 32'd0;
            r_req_addr <= RESET_PC;
        end else begin
            if (w_load_buf) begin
                r_buf_inst <= w_cap_inst;
                r_buf_excp <= w_cap_excp;
            end
            // Frozen in DISCARD so the abandoned request keeps its address.
            if (r_state != ST_DISCARD) begin
                r_req_addr <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_if_inst   <= 32'd0;
            r_pend_br   <= 1'b0;
            r_br_target <= 32'd0;
        end else if (flush) begin
            r_pc      <= flush_pc;
            r_if_inst <= 32'd0;
            r_pend_br <= 1'b0;
        end else if (w_advance) begin
            r_pc      <= w_next_pc;
            r_if_inst <= r_buf_inst;
            r_pend_br <= 1'b0;
        end else if (branch_en) begin
            r_pend_br   <= 1'b1;
            r_br_target <= branch_pc;
        end
    end

    assign ibus.req  = w_req && rst_n;
    assign ibus.addr = w_addr;

    assign if_pc    = r_pc;
    assign if_inst  = r_if_inst;
    assign if_excp  = (r_state == ST_DONE) ? r_buf_excp : 32'd0;
    assign if_stall = (r_state != ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// Module      : tb_pc_fetch
// Description : Directed self-checking bench for pc_fetch with a simple
//               latency-programmable instruction memory (rdata = ~addr).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_en;
    logic [31:0] branch_pc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_excp;
    logic        if_stall;

    int          n_tests;
    int          n_fail;

    int          slv_lat;
    int          slv_cnt;
    logic        force_en;
    logic [31:0] force_data;
    logic        err_en;

    pc_fetch_if bus();

    pc_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .branch_en (branch_en),
        .branch_pc (branch_pc),
        .ibus      (bus),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_excp   (if_excp),
        .if_stall  (if_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ack   = bus.req && (slv_cnt >= slv_lat);
    assign bus.rdata = force_en ? force_data : ~bus.addr;
    assign bus.err   = err_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    slv_cnt <= 0;
        else if (bus.req && !bus.ack)  slv_cnt <= slv_cnt + 1;
        else                           slv_cnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_offer();
        int n;
        n = 0;
        while (if_stall && n < 20) begin
            tick();
            n++;
        end
        if (if_stall) begin
            n_fail++;
            $display("FAIL wait_offer: if_stall still %b after %0d cycles, required 0", if_stall, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_tests++; if (if_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", if_pc, 32'hBFC0_0000); end
        n_tests++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", if_stall); end
        n_tests++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.req); end
        n_tests++; if (bus.addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus.addr, 32'hBFC0_0000); end
        n_tests++; if (if_excp !== 32'd0) begin n_fail++; $display("FAIL reset_excp: got %h want 0", if_excp); end
        n_tests++; if (if_inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", if_inst); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        for (int i = 0; i < 4; i++) begin
            exp_pc   = 32'hBFC0_0000 + 32'(4 * i);
            exp_inst = (i == 0) ? 32'd0 : ~(exp_pc - 32'd4);
            wait_offer();
            n_tests++; if (if_pc !== exp_pc) begin n_fail++; $display("FAIL zw_pc[%0d]: got %h want %h", i, if_pc, exp_pc); end
            n_tests++; if (if_inst !== exp_inst) begin n_fail++; $display("FAIL zw_inst[%0d]: got %h want %h", i, if_inst, exp_inst); end
            n_tests++; if (if_excp !== 32'd0) begin n_fail++; $display("FAIL zw_excp[%0d]: got %h want 0", i, if_excp); end
            tick();
        end
    endtask

    task automatic test_wait_states();
        slv_lat = 3;
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL ws_stall[%0d]: got %b want 1", k, if_stall); end
            n_tests++; if (bus.req !== 1'b1 || bus.addr !== 32'hBFC0_0010) begin n_fail++; $display("FAIL ws_bus[%0d]: got req=%b addr=%h want req=1 addr=%h", k, bus.req, bus.addr, 32'hBFC0_0010); end
            tick();
        end
        wait_offer();
        n_tests++; if (if_pc !== 32'hBFC0_0010) begin n_fail++; $display("FAIL ws_pc: got %h want %h", if_pc, 32'hBFC0_0010); end
        n_tests++; if (if_inst !== 32'h403F_FFF3) begin n_fail++; $display("FAIL ws_inst_hold: got %h want %h", if_inst, 32'h403F_FFF3); end
        slv_lat = 0;
        tick();
        n_tests++; if (if_inst !== 32'h403F_FFEF) begin n_fail++; $display("FAIL ws_inst: got %h want %h", if_inst, 32'h403F_FFEF); end
        wait_offer();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++; if (if_pc !== 32'hBFC0_0014 || if_inst !== 32'h403F_FFEF || if_excp !== 32'd0 || if_stall !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h inst=%h excp=%h stall=%b want pc=BFC00014 inst=403FFFEF excp=0 stall=0", k, if_pc, if_inst, if_excp, if_stall); end
            n_tests++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", k, bus.req); end
        end
        stall = 1'b0;
        tick();
        n_tests++; if (if_pc !== 32'hBFC0_0018 || if_inst !== 32'h403F_FFEB) begin n_fail++; $display("FAIL stall_release: got pc=%h inst=%h want pc=BFC00018 inst=403FFFEB", if_pc, if_inst); end
        wait_offer();
        n_tests++; if (if_pc !== 32'hBFC0_0018) begin n_fail++; $display("FAIL stall_once: got %h want %h", if_pc, 32'hBFC0_0018); end
    endtask

    task automatic test_branch();
        tick();
        branch_en = 1'b1; branch_pc = 32'h8000_0100;
        tick();
        branch_en = 1'b0;
        n_tests++; if (if_pc !== 32'hBFC0_001C || if_stall !== 1'b0) begin n_fail++; $display("FAIL br_slot: got pc=%h stall=%b want pc=BFC0001C stall=0", if_pc, if_stall); end
        tick();
        n_tests++; if (if_inst !== 32'h403F_FFE3) begin n_fail++; $display("FAIL br_slot_inst: got %h want %h", if_inst, 32'h403F_FFE3); end
        wait_offer();
        n_tests++; if (if_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL br_target: got %h want %h", if_pc, 32'h8000_0100); end
        branch_en = 1'b1; branch_pc = 32'h8000_0200;
        tick();
        branch_en = 1'b0;
        wait_offer();
        n_tests++; if (if_pc !== 32'h8000_0200) begin n_fail++; $display("FAIL br_coincide: got %h want %h", if_pc, 32'h8000_0200); end
        tick();
        wait_offer();
        n_tests++; if (if_pc !== 32'h8000_0204) begin n_fail++; $display("FAIL br_cleared: got %h want %h", if_pc, 32'h8000_0204); end
    endtask

    task automatic test_flush();
        slv_lat = 2;
        tick();
        tick();
        flush = 1'b1; flush_pc = 32'h8000_0180;
        force_en = 1'b1; force_data = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0;
        n_tests++; if (if_inst !== 32'd0) begin n_fail++; $display("FAIL fl_inst_clear: got %h want 0", if_inst); end
        n_tests++; if (bus.req !== 1'b1 || bus.addr !== 32'h8000_0208 || bus.ack !== 1'b1) begin n_fail++; $display("FAIL fl_discard_bus: got req=%b addr=%h ack=%b want 1 80000208 1", bus.req, bus.addr, bus.ack); end
        n_tests++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fl_discard_stall: got %b want 1", if_stall); end
        tick();
        force_en = 1'b0; slv_lat = 0;
        n_tests++; if (bus.req !== 1'b1 || bus.addr !== 32'h8000_0180) begin n_fail++; $display("FAIL fl_refetch: got req=%b addr=%h want 1 80000180", bus.req, bus.addr); end
        wait_offer();
        n_tests++; if (if_pc !== 32'h8000_0180 || if_inst !== 32'd0 || if_excp !== 32'd0) begin n_fail++; $display("FAIL fl_offer: got pc=%h inst=%h excp=%h want 80000180 0 0", if_pc, if_inst, if_excp); end
        tick();
        n_tests++; if (if_inst !== 32'h7FFF_FE7F) begin n_fail++; $display("FAIL fl_data: got %h want %h", if_inst, 32'h7FFF_FE7F); end
    endtask

    task automatic test_adel();
        wait_offer();
        branch_en = 1'b1; branch_pc = 32'h8000_0102;
        tick();
        branch_en = 1'b0;
        n_tests++; if (bus.req !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL adel_noreq: got req=%b stall=%b want 0 1", bus.req, if_stall); end
        tick();
        n_tests++; if (if_pc !== 32'h8000_0102 || if_excp !== 32'h0000_0001 || if_stall !== 1'b0) begin n_fail++; $display("FAIL adel_excp: got pc=%h excp=%h stall=%b want 80000102 1 0", if_pc, if_excp, if_stall); end
        tick();
        n_tests++; if (if_inst !== 32'd0) begin n_fail++; $display("FAIL adel_inst: got %h want 0", if_inst); end
        flush = 1'b1; flush_pc = 32'h8000_0300;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_ibe();
        err_en = 1'b1;
        wait_offer();
        n_tests++; if (if_pc !== 32'h8000_0300 || if_excp !== 32'h0000_0002) begin n_fail++; $display("FAIL ibe_excp: got pc=%h excp=%h want 80000300 2", if_pc, if_excp); end
        err_en = 1'b0;
        tick();
        n_tests++; if (if_inst !== 32'h7FFF_FCFF) begin n_fail++; $display("FAIL ibe_inst: got %h want %h", if_inst, 32'h7FFF_FCFF); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        wait_offer();
        n_tests++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want FFFFFFFC", if_pc); end
        tick();
        wait_offer();
        n_tests++; if (if_pc !== 32'd0 || if_inst !== 32'h0000_0003) begin n_fail++; $display("FAIL wrap_zero: got pc=%h inst=%h want 0 3", if_pc, if_inst); end
    endtask

    task automatic test_async_reset();
        slv_lat = 5;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.req !== 1'b0 || if_pc !== 32'hBFC0_0000 || if_stall !== 1'b1 || if_inst !== 32'd0) begin
            n_fail++; $display("FAIL arst: got req=%b pc=%h stall=%b inst=%h want 0 BFC00000 1 0", bus.req, if_pc, if_stall, if_inst); end
        tick();
        slv_lat = 0;
        rst_n = 1'b1;
        wait_offer();
        n_tests++; if (if_pc !== 32'hBFC0_0000 || if_inst !== 32'd0) begin n_fail++; $display("FAIL arst_refetch: got pc=%h inst=%h want BFC00000 0", if_pc, if_inst); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        stall = 1'b0; flush = 1'b0; flush_pc = 32'd0;
        branch_en = 1'b0; branch_pc = 32'd0;
        slv_lat = 0; force_en = 1'b0; force_data = 32'd0; err_en = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch();
        test_flush();
        test_adel();
        test_ibe();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
